id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register for the pipelined MIPS core; sits directly downstream of the main decoder.
//  Captures decoder control bits and register/immediate operands each cycle and presents them to EX.
//  Detects load-use hazards, inserts bubbles, and honours flush and back-pressure requests.
// PARAMETERS
//  DATA_W        32  operand/PC width
//  REG_AW        5   register-specifier width
//  LU_BUBBLES    1   bubbles inserted per load-use hazard (1..3)
// PORTS
//  clk           in   1       rising-edge clock
//  reset_n       in   1       asynchronous, active-low reset
//  valid_d       in   1       ID holds a real instruction
//  regwrite_d, memtoreg_d, memwrite_d, branch_d, alusrc_d, regdst_d, jump_d, ori_d, bne_d  in 1 each  decoder controls
//  aluop_d       in   2       decoder ALU op class
//  rd1_d, rd2_d  in   DATA_W  register-file read data
//  signimm_d     in   DATA_W  extended immediate
//  pcplus4_d     in   DATA_W  PC+4 of ID instruction
//  rs_d, rt_d, rd_d in REG_AW register specifiers
//  flush_e       in   1       kill ID instruction (branch/jump resolved taken)
//  hold_e        in   1       downstream back-pressure: freeze EX contents
//  <all *_d above>_e  out same  registered copies for EX
//  valid_e       out  1       EX slot holds a real instruction
//  stall_d       out  1       freeze PC and IF/ID (combinational)
// BEHAVIOUR
//  Reset: every *_e output and valid_e = 0; bubble counter = 0; FSM = RUN. Async assert, sync deassert.
//  Hazard: lu_hit = valid_e & memtoreg_e & (rt_e!=0) & ((rt_e==rs_d) | (rt_e==rt_d)) & valid_d.
//  FSM RUN: lu_hit & !hold_e -> load bubble, cnt=LU_BUBBLES-1; if cnt!=0 go BUBBLE else stay RUN.
//  FSM BUBBLE: load bubble each non-held cycle, cnt--; at cnt==0 -> RUN. stall_d=1 throughout.
//  stall_d = (RUN & lu_hit) | BUBBLE | hold_e.
//  Bubble: valid_e=0, regwrite_e=memwrite_e=branch_e=jump_e=bne_e=0; data fields don't-care (hold).
//  Priority per edge: reset > hold_e (all regs keep, FSM frozen) > flush_e (load bubble, FSM->RUN,
//   cnt=0) > hazard bubble > normal load of *_d with valid_e=valid_d.
//  !valid_d without flush: load bubble (valid_e=0, side-effect controls forced 0).
//  Latency: 1 cycle D->E. Throughput 1 instr/cycle absent stalls.
//  flush_e during BUBBLE aborts remaining bubbles; hold_e during BUBBLE does not decrement cnt.
//  rt_e==0 never triggers a hazard ($zero). Reset mid-BUBBLE returns to RUN, valid_e=0.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs lu_stalls[31:0], flushes[31:0]; lu_stalls +1 per
//   hazard-bubble cycle loaded, flushes +1 per flush_e edge not masked by hold_e; both wrap
//   at 2^32, reset to 0.
//  Undefined: ports and counters absent; core behaviour identical.
// TESTING
//  Reset: reset_n=0 mid-stream -> all *_e=0, valid_e=0, stall_d=0 immediately (async).
//  Pass-through: R-type, rd1_d=0x11, rd2_d=0x22, rd_d=5, regwrite_d=1 -> next cycle same on *_e,
//   valid_e=1.
//  Load-use: lw rt=8 in EX, add rs_d=8 in ID, LU_BUBBLES=1 -> stall_d=1 one cycle, one bubble,
//   add enters EX next cycle.
//  LU_BUBBLES=3, rt_e=0 vs rs_d=0 -> no stall; rt_e=9==rt_d -> 3 bubble cycles, stall_d=1 x3.
//  flush_e=1 with regwrite_d=1 -> valid_e=0, regwrite_e=0; flush_e during BUBBLE -> FSM RUN next cycle.
//  hold_e=1 for 2 cycles -> *_e unchanged, stall_d=1; HAZARD_STATS_EN: lu_stalls/flushes count exactly.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion, flush and hold.
// Optional hazard statistics counters are enabled with `define HAZARD_STATS_EN.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int LU_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_d,
  input  logic              regwrite_d,
  input  logic              memtoreg_d,
  input  logic              memwrite_d,
  input  logic              branch_d,
  input  logic              alusrc_d,
  input  logic              regdst_d,
  input  logic              jump_d,
  input  logic              ori_d,
  input  logic              bne_d,
  input  logic [1:0]        aluop_d,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic [DATA_W-1:0] signimm_d,
  input  logic [DATA_W-1:0] pcplus4_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              flush_e,
  input  logic              hold_e,
  output logic              valid_e,
  output logic              regwrite_e,
  output logic              memtoreg_e,
  output logic              memwrite_e,
  output logic              branch_e,
  output logic              alusrc_e,
  output logic              regdst_e,
  output logic              jump_e,
  output logic              ori_e,
  output logic              bne_e,
  output logic [1:0]        aluop_e,
  output logic [DATA_W-1:0] rd1_e,
  output logic [DATA_W-1:0] rd2_e,
  output logic [DATA_W-1:0] signimm_e,
  output logic [DATA_W-1:0] pcplus4_e,
  output logic [REG_AW-1:0] rs_e,
  output logic [REG_AW-1:0] rt_e,
  output logic [REG_AW-1:0] rd_e,
`ifdef HAZARD_STATS_EN
  output logic [31:0]       lu_stalls,
  output logic [31:0]       flushes,
`endif
  output logic              stall_d
);

  typedef enum logic {RUN, BUBBLE} state_t;
  typedef enum logic [1:0] {LD_HOLD, LD_BUBBLE, LD_INSTR} load_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  load_t      loadSel;
  logic       luHit;
  logic       hazBubble;

  // $zero is never a real producer, so rt_e==0 cannot create a dependency
  assign luHit = valid_e & memtoreg_e & (rt_e != '0) &
                 ((rt_e == rs_d) | (rt_e == rt_d)) & valid_d;

  assign stall_d = ((state_q == RUN) & luHit) | (state_q == BUBBLE) | hold_e;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    loadSel   = LD_INSTR;
    hazBubble = 1'b0;
    if (hold_e) begin
      loadSel = LD_HOLD;
    end else if (flush_e) begin
      loadSel = LD_BUBBLE;
      state_d = RUN;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (luHit) begin
            loadSel   = LD_BUBBLE;
            hazBubble = 1'b1;
            cnt_d     = 2'(LU_BUBBLES - 1);
            state_d   = (LU_BUBBLES > 1) ? BUBBLE : RUN;
          end else if (!valid_d) begin
            loadSel = LD_BUBBLE;
          end
        end
        BUBBLE: begin
          loadSel   = LD_BUBBLE;
          hazBubble = 1'b1;
          // cnt counts bubbles still owed after this one
          cnt_d     = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
          if (cnt_q <= 2'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_e    <= 1'b0;
      regwrite_e <= 1'b0;
      memtoreg_e <= 1'b0;
      memwrite_e <= 1'b0;
      branch_e   <= 1'b0;
      alusrc_e   <= 1'b0;
      regdst_e   <= 1'b0;
      jump_e     <= 1'b0;
      ori_e      <= 1'b0;
      bne_e      <= 1'b0;
      aluop_e    <= 2'd0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      signimm_e  <= '0;
      pcplus4_e  <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
    end else begin
      case (loadSel)
        LD_INSTR: begin
          valid_e    <= valid_d;
          regwrite_e <= regwrite_d;
          memtoreg_e <= memtoreg_d;
          memwrite_e <= memwrite_d;
          branch_e   <= branch_d;
          alusrc_e   <= alusrc_d;
          regdst_e   <= regdst_d;
          jump_e     <= jump_d;
          ori_e      <= ori_d;
          bne_e      <= bne_d;
          aluop_e    <= aluop_d;
          rd1_e      <= rd1_d;
          rd2_e      <= rd2_d;
          signimm_e  <= signimm_d;
          pcplus4_e  <= pcplus4_d;
          rs_e       <= rs_d;
          rt_e       <= rt_d;
          rd_e       <= rd_d;
        end
        // A bubble only has to kill state-changing controls; data fields may stay stale
        LD_BUBBLE: begin
          valid_e    <= 1'b0;
          regwrite_e <= 1'b0;
          memwrite_e <= 1'b0;
          branch_e   <= 1'b0;
          jump_e     <= 1'b0;
          bne_e      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lu_stalls <= '0;
      flushes   <= '0;
    end else begin
      if (hazBubble)          lu_stalls <= lu_stalls + 32'd1;
      if (flush_e && !hold_e) flushes   <= flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: one instance with LU_BUBBLES=1 (a_*) and one with 3 (b_*),
// both fed the same ID-side stimulus.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_d, regwrite_d, memtoreg_d, memwrite_d, branch_d, alusrc_d, regdst_d;
  logic        jump_d, ori_d, bne_d, flush_e, hold_e;
  logic [1:0]  aluop_d;
  logic [31:0] rd1_d, rd2_d, signimm_d, pcplus4_d;
  logic [4:0]  rs_d, rt_d, rd_d;

  logic        a_valid, a_regwrite, a_memtoreg, a_memwrite, a_branch, a_alusrc, a_regdst;
  logic        a_jump, a_ori, a_bne, a_stall;
  logic [1:0]  a_aluop;
  logic [31:0] a_rd1, a_rd2, a_signimm, a_pcplus4;
  logic [4:0]  a_rs, a_rt, a_rd;
  logic        b_valid, b_regwrite, b_memtoreg, b_memwrite, b_branch, b_alusrc, b_regdst;
  logic        b_jump, b_ori, b_bne, b_stall;
  logic [1:0]  b_aluop;
  logic [31:0] b_rd1, b_rd2, b_signimm, b_pcplus4;
  logic [4:0]  b_rs, b_rt, b_rd;
`ifdef HAZARD_STATS_EN
  logic [31:0] a_luStalls, a_flushes, b_luStalls, b_flushes;
`endif

  int checkCnt = 0;
  int passCnt  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .LU_BUBBLES(1)) dutA (
    .clk(clk), .reset_n(reset_n), .valid_d(valid_d), .regwrite_d(regwrite_d),
    .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d), .branch_d(branch_d), .alusrc_d(alusrc_d),
    .regdst_d(regdst_d), .jump_d(jump_d), .ori_d(ori_d), .bne_d(bne_d), .aluop_d(aluop_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d), .pcplus4_d(pcplus4_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .flush_e(flush_e), .hold_e(hold_e),
    .valid_e(a_valid), .regwrite_e(a_regwrite), .memtoreg_e(a_memtoreg), .memwrite_e(a_memwrite),
    .branch_e(a_branch), .alusrc_e(a_alusrc), .regdst_e(a_regdst), .jump_e(a_jump),
    .ori_e(a_ori), .bne_e(a_bne), .aluop_e(a_aluop), .rd1_e(a_rd1), .rd2_e(a_rd2),
    .signimm_e(a_signimm), .pcplus4_e(a_pcplus4), .rs_e(a_rs), .rt_e(a_rt), .rd_e(a_rd),
`ifdef HAZARD_STATS_EN
    .lu_stalls(a_luStalls), .flushes(a_flushes),
`endif
    .stall_d(a_stall)
  );

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .LU_BUBBLES(3)) dutB (
    .clk(clk), .reset_n(reset_n), .valid_d(valid_d), .regwrite_d(regwrite_d),
    .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d), .branch_d(branch_d), .alusrc_d(alusrc_d),
    .regdst_d(regdst_d), .jump_d(jump_d), .ori_d(ori_d), .bne_d(bne_d), .aluop_d(aluop_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d), .pcplus4_d(pcplus4_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .flush_e(flush_e), .hold_e(hold_e),
    .valid_e(b_valid), .regwrite_e(b_regwrite), .memtoreg_e(b_memtoreg), .memwrite_e(b_memwrite),
    .branch_e(b_branch), .alusrc_e(b_alusrc), .regdst_e(b_regdst), .jump_e(b_jump),
    .ori_e(b_ori), .bne_e(b_bne), .aluop_e(b_aluop), .rd1_e(b_rd1), .rd2_e(b_rd2),
    .signimm_e(b_signimm), .pcplus4_e(b_pcplus4), .rs_e(b_rs), .rt_e(b_rt), .rd_e(b_rd),
`ifdef HAZARD_STATS_EN
    .lu_stalls(b_luStalls), .flushes(b_flushes),
`endif
    .stall_d(b_stall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one ID-stage instruction; unlisted controls default to 0
  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic [31:0] d1, input logic [31:0] d2);
    valid_d = v; rs_d = rs; rt_d = rt; rd_d = rd; regwrite_d = rw; memtoreg_d = mr;
    rd1_d = d1; rd2_d = d2; alusrc_d = mr; regdst_d = ~mr; aluop_d = mr ? 2'd0 : 2'd2;
    memwrite_d = 1'b0; branch_d = 1'b0; jump_d = 1'b0; ori_d = 1'b0; bne_d = 1'b0;
    signimm_d = 32'h4; pcplus4_d = 32'h100;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; flush_e = 1'b0; hold_e = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    checkOutput("rst_valid", {31'd0, a_valid}, 32'd0);
    checkOutput("rst_stall", {31'd0, a_stall}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    tick();

    // Pass-through R-type
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 32'h11, 32'h22);
    tick();
    checkOutput("pt_valid", {31'd0, a_valid}, 32'd1);
    checkOutput("pt_rd1", a_rd1, 32'h11);
    checkOutput("pt_rd2", a_rd2, 32'h22);
    checkOutput("pt_rd", {27'd0, a_rd}, 32'd5);
    checkOutput("pt_regwrite", {31'd0, a_regwrite}, 32'd1);
    checkOutput("pt_aluop", {30'd0, a_aluop}, 32'd2);

    // Load into $zero must not stall a consumer of $zero
    applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("zero_stallA", {31'd0, a_stall}, 32'd0);
    checkOutput("zero_stallB", {31'd0, b_stall}, 32'd0);
    tick();
    checkOutput("zero_valid", {31'd0, a_valid}, 32'd1);

    // LU_BUBBLES=1: lw r8 then add using rs=8
    applyStimulus(1'b1, 5'd3, 5'd8, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 5'd8, 5'd4, 5'd10, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("lu1_stall", {31'd0, a_stall}, 32'd1);
    tick();
    checkOutput("lu1_bub_valid", {31'd0, a_valid}, 32'd0);
    checkOutput("lu1_bub_rw", {31'd0, a_regwrite}, 32'd0);
    checkOutput("lu1_stall_off", {31'd0, a_stall}, 32'd0);
    tick();
    checkOutput("lu1_add_valid", {31'd0, a_valid}, 32'd1);
    checkOutput("lu1_add_rd", {27'd0, a_rd}, 32'd10);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // LU_BUBBLES=3: lw r9 then sub using rt=9
    applyStimulus(1'b1, 5'd3, 5'd9, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 5'd2, 5'd9, 5'd11, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("lu3_stall0", {31'd0, b_stall}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput($sformatf("lu3_bub%0d_valid", i), {31'd0, b_valid}, 32'd0);
      checkOutput($sformatf("lu3_stall%0d", i), {31'd0, b_stall}, (i < 3) ? 32'd1 : 32'd0);
    end
    tick();
    checkOutput("lu3_sub_valid", {31'd0, b_valid}, 32'd1);
    checkOutput("lu3_sub_rd", {27'd0, b_rd}, 32'd11);

    // Plain flush kills a regwrite instruction
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 32'h0, 32'h0);
    flush_e = 1'b1;
    tick();
    flush_e = 1'b0;
    checkOutput("fl_valid", {31'd0, a_valid}, 32'd0);
    checkOutput("fl_regwrite", {31'd0, a_regwrite}, 32'd0);

    // Flush while dutB is in BUBBLE aborts remaining bubbles
    applyStimulus(1'b1, 5'd3, 5'd9, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 5'd2, 5'd9, 5'd11, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("flb_in_bubble", {31'd0, b_stall}, 32'd1);
    flush_e = 1'b1;
    tick();
    flush_e = 1'b0;
    #1;
    checkOutput("flb_valid", {31'd0, b_valid}, 32'd0);
    checkOutput("flb_run", {31'd0, b_stall}, 32'd0);
    tick();
    checkOutput("flb_sub_valid", {31'd0, b_valid}, 32'd1);

    // Hold for two cycles freezes EX contents
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd13, 1'b1, 1'b0, 32'h55, 32'h0);
    tick();
    checkOutput("hd_pre_rd1", a_rd1, 32'h55);
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd14, 1'b1, 1'b0, 32'h66, 32'h0);
    hold_e = 1'b1;
    #1;
    checkOutput("hd_stall", {31'd0, a_stall}, 32'd1);
    for (int i = 1; i <= 2; i++) begin
      tick();
      checkOutput($sformatf("hd%0d_rd1", i), a_rd1, 32'h55);
      checkOutput($sformatf("hd%0d_rd", i), {27'd0, a_rd}, 32'd13);
      checkOutput($sformatf("hd%0d_stall", i), {31'd0, a_stall}, 32'd1);
    end
    hold_e = 1'b0;
    tick();
    checkOutput("hd_release_rd1", a_rd1, 32'h66);

`ifdef HAZARD_STATS_EN
    checkOutput("stA_lu", a_luStalls, 32'd3);
    checkOutput("stB_lu", b_luStalls, 32'd7);
    checkOutput("stA_fl", a_flushes, 32'd2);
    checkOutput("stB_fl", b_flushes, 32'd2);
`endif

    // Asynchronous reset while dutB is mid-BUBBLE
    applyStimulus(1'b1, 5'd3, 5'd9, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 5'd2, 5'd9, 5'd11, 1'b1, 1'b0, 32'h77, 32'h0);
    tick();
    tick();
    checkOutput("ar_pre_stall", {31'd0, b_stall}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("ar_validA", {31'd0, a_valid}, 32'd0);
    checkOutput("ar_rwA", {31'd0, a_regwrite}, 32'd0);
    checkOutput("ar_rd1A", a_rd1, 32'h0);
    checkOutput("ar_validB", {31'd0, b_valid}, 32'd0);
    checkOutput("ar_stallB", {31'd0, b_stall}, 32'd0);
`ifdef HAZARD_STATS_EN
    checkOutput("ar_statsB", b_luStalls, 32'd0);
`endif
    @(negedge clk); reset_n = 1'b1;
    tick();
    checkOutput("ar_post_valid", {31'd0, b_valid}, 32'd1);
    checkOutput("ar_post_rd1", b_rd1, 32'h77);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
